x_collector: RTL and testbench

Response-path companion to the tester command driver: gathers read data returned by up to 16 23K640 channel controllers and serialises it back to the tester byte link. Each controller's ready pulse captures its read byte into a per-channel holding slot. A round-robin arbiter drains pending slots as framed byte sequences to the tester transmitter, honouring its busy signal. Sits between the channel controllers' i_ready/i_rdata outputs and the tester-side transmit interface.

---
 rtl/x_collector.sv | 153 +++++++++++++++
 tb/tb_x_collector.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/x_collector.sv
// Response collector: captures per-channel read bytes and drains them round-robin as framed bytes to the tester link.
// Optional build macro X_COLLECTOR_TIMESTAMP_EN appends a per-capture 8-bit cycle timestamp byte to each frame.
module x_collector #(
  parameter int unsigned p_channels = 16,
  parameter int unsigned p_width    = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [p_channels-1:0]           i_ready,
  input  logic [p_channels*p_width-1:0]   i_rdata,
  input  logic                            i_test_busy,
  output logic                            o_test_valid,
  output logic [7:0]                      o_test_data,
  output logic [p_channels-1:0]           o_pending,
  output logic                            o_idle
);

`ifdef X_COLLECTOR_TIMESTAMP_EN
  localparam logic TS_FLAG = 1'b1;
  typedef enum logic [2:0] {IDLE, HDR, HGAP, DAT, DGAP, TS, TGAP} state_t;
`else
  localparam logic TS_FLAG = 1'b0;
  typedef enum logic [2:0] {IDLE, HDR, HGAP, DAT, DGAP} state_t;
`endif

  state_t                  state_q, state_d;
  logic [3:0]              chan_q, ptr_q, grant_idx;
  logic                    grant_found;
  int unsigned             k;
  logic [p_width-1:0]      slot_q [p_channels];
  logic [p_channels-1:0]   pend_q, ovf_q, consume;
  logic [7:0]              data_q, tx_byte;
  logic                    fire, dat_fire;

`ifdef X_COLLECTOR_TIMESTAMP_EN
  logic [7:0]              cnt_q, ts_q;
  logic [7:0]              ts_slot_q [p_channels];
`endif

  // Round-robin search: first pending channel at or after ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    k           = 0;
    for (int unsigned i = 0; i < p_channels; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= p_channels) k = k - p_channels;
      if (!grant_found && pend_q[k[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = k[3:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_byte = data_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: if (grant_found) state_d = HDR;
      HDR: if (!i_test_busy) begin
        fire    = 1'b1;
        tx_byte = {chan_q, ovf_q[chan_q], TS_FLAG, 2'b10};
        state_d = HGAP;
      end
      HGAP: state_d = DAT;
      DAT: if (!i_test_busy) begin
        fire    = 1'b1;
        tx_byte = slot_q[chan_q];
`ifdef X_COLLECTOR_TIMESTAMP_EN
        state_d = TS;
`else
        state_d = DGAP;
`endif
      end
      DGAP: state_d = IDLE;
`ifdef X_COLLECTOR_TIMESTAMP_EN
      TS: if (!i_test_busy) begin
        fire    = 1'b1;
        tx_byte = ts_q;
        state_d = TGAP;
      end
      TGAP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign dat_fire = fire && (state_q == DAT);

  always_comb begin
    consume = '0;
    if (dat_fire) consume[chan_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fire) data_q <= tx_byte;
      if (state_q == IDLE && grant_found) begin
        chan_q <= grant_idx;
        ptr_q  <= (32'(grant_idx) == p_channels - 1) ? '0 : grant_idx + 4'd1;
      end
    end
  end

  // A capture coinciding with consumption keeps the slot pending; overflow
  // is only flagged when an undelivered byte is overwritten.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
      for (int unsigned n = 0; n < p_channels; n++) slot_q[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < p_channels; n++) begin
        if (i_ready[n]) begin
          slot_q[n] <= i_rdata[n*p_width +: p_width];
          pend_q[n] <= 1'b1;
          ovf_q[n]  <= !consume[n] && (ovf_q[n] | pend_q[n]);
        end else if (consume[n]) begin
          pend_q[n] <= 1'b0;
          ovf_q[n]  <= 1'b0;
        end
      end
    end
  end

`ifdef X_COLLECTOR_TIMESTAMP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ts_q  <= '0;
      for (int unsigned n = 0; n < p_channels; n++) ts_slot_q[n] <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (dat_fire) ts_q <= ts_slot_q[chan_q];
      for (int unsigned n = 0; n < p_channels; n++)
        if (i_ready[n]) ts_slot_q[n] <= cnt_q;
    end
  end
`endif

  assign o_test_valid = fire;
  assign o_test_data  = tx_byte;
  assign o_pending    = pend_q;
  assign o_idle       = (state_q == IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_x_collector.sv
// Self-checking bench for x_collector: table of single reads plus directed multi-cycle sequences.
module tb_x_collector;
  localparam int unsigned NCH = 16;
`ifdef X_COLLECTOR_TIMESTAMP_EN
  localparam logic [7:0] TSB = 8'h04;
  localparam int FL = 3;
`else
  localparam logic [7:0] TSB = 8'h00;
  localparam int FL = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ready;
  logic [NCH*8-1:0] rdata;
  logic             busy;
  logic             valid;
  logic [7:0]       tdata;
  logic [NCH-1:0]   pending;
  logic             idle;

  always #5 clk = ~clk;

  x_collector #(.p_channels(NCH), .p_width(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready), .i_rdata(rdata),
    .i_test_busy(busy), .o_test_valid(valid), .o_test_data(tdata),
    .o_pending(pending), .o_idle(idle)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got[$];
  int unsigned got_cyc[$];
  always @(negedge clk) begin
    if (valid) begin
      got.push_back(tdata);
      got_cyc.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic [7:0] hdr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cap1(input int ch, input logic [7:0] d);
    ready = '0;
    ready[ch] = 1'b1;
    rdata[ch*8 +: 8] = d;
    step(1);
    ready = '0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int b;
    b = 0;
    while (got.size() < n && b < 300) begin
      step(1);
      b++;
    end
    if (got.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got %0d bytes expected %0d", name, got.size(), n);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] hdr, input logic [7:0] dat,
                              input bit chk_ts, input logic [7:0] ts, output int unsigned hcyc);
    hcyc = 0;
    wait_bytes(FL, name);
    if (got.size() >= FL) begin
      hcyc = got_cyc[0];
      check({name, "_hdr"}, got[0], hdr);
      check({name, "_dat"}, got[1], dat);
      if (FL == 3 && chk_ts) check({name, "_ts"}, got[2], ts);
      for (int i = 0; i < FL; i++) begin
        void'(got.pop_front());
        void'(got_cyc.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, hc, rcyc;
    vecs[0] = '{3,  8'hA5, 8'h32};
    vecs[1] = '{15, 8'hFF, 8'hF2};
    vecs[2] = '{8,  8'h00, 8'h82};
    vecs[3] = '{10, 8'h5A, 8'hA2};
    vecs[4] = '{6,  8'h3C, 8'h62};

    rst_n = 1'b0; ready = '0; rdata = '0; busy = 1'b0;
    step(2);
    check("rst_valid", valid, 0);
    check("rst_data", tdata, 0);
    check("rst_pending", pending, 0);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;
    step(1);

    foreach (vecs[i]) begin
      k = cyc;
      cap1(vecs[i].ch, vecs[i].d);
      expect_frame($sformatf("vec%0d", i), vecs[i].hdr | TSB, vecs[i].d, 1'b0, 8'h00, hc);
      check($sformatf("vec%0d_latency", i), hc - k, 2);
      step(2);
      check($sformatf("vec%0d_pending", i), pending, 0);
      check($sformatf("vec%0d_idle", i), idle, 1);
    end

    busy = 1'b1;
    cap1(0, 8'h11);
    step(10);
    check("stall_no_strobe", got.size(), 0);
    check("stall_pending", pending, 32'h0001);
    busy = 1'b0;
    expect_frame("stall", 8'h02 | TSB, 8'h11, 1'b0, 8'h00, hc);
    step(2);

    ready = '0;
    ready[1] = 1'b1;  rdata[1*8 +: 8]  = 8'h01;
    ready[5] = 1'b1;  rdata[5*8 +: 8]  = 8'h05;
    ready[14] = 1'b1; rdata[14*8 +: 8] = 8'h0E;
    step(1);
    ready = '0;
    expect_frame("rr_ch1", 8'h12 | TSB, 8'h01, 1'b0, 8'h00, hc);
    expect_frame("rr_ch5", 8'h52 | TSB, 8'h05, 1'b0, 8'h00, hc);
    expect_frame("rr_ch14", 8'hE2 | TSB, 8'h0E, 1'b0, 8'h00, hc);
    step(2);
    check("rr_idle", idle, 1);

    ready = '0;
    ready[2] = 1'b1;  rdata[2*8 +: 8]  = 8'hB2;
    ready[15] = 1'b1; rdata[15*8 +: 8] = 8'hBF;
    step(1);
    ready = '0;
    expect_frame("wrap_ch15", 8'hF2 | TSB, 8'hBF, 1'b0, 8'h00, hc);
    expect_frame("wrap_ch2", 8'h22 | TSB, 8'hB2, 1'b0, 8'h00, hc);
    step(2);

    busy = 1'b1;
    cap1(7, 8'h10);
    step(3);
    cap1(7, 8'h20);
    step(2);
    busy = 1'b0;
    expect_frame("ovf", 8'h7A | TSB, 8'h20, 1'b0, 8'h00, hc);
    step(2);
    cap1(7, 8'h55);
    expect_frame("ovf_clear", 8'h72 | TSB, 8'h55, 1'b0, 8'h00, hc);
    step(2);

    busy = 1'b1;
    cap1(4, 8'h44);
    step(3);
    busy = 1'b0;
    step(2);
    ready[4] = 1'b1;
    rdata[4*8 +: 8] = 8'h99;
    step(1);
    ready = '0;
    expect_frame("consume_old", 8'h42 | TSB, 8'h44, 1'b0, 8'h00, hc);
    expect_frame("consume_new", 8'h42 | TSB, 8'h99, 1'b0, 8'h00, hc);
    step(2);

    cap1(6, 8'hC3);
    wait_bytes(1, "midrst_hdr");
    rst_n = 1'b0;
    got.delete();
    got_cyc.delete();
    step(2);
    check("midrst_valid", valid, 0);
    check("midrst_data", tdata, 0);
    check("midrst_pending", pending, 0);
    check("midrst_idle", idle, 1);
    rst_n = 1'b1;
    rcyc = cyc;
    step(4);
    check("midrst_no_strobe", got.size(), 0);
    k = cyc;
    cap1(2, 8'h33);
    expect_frame("post_rst", 8'h22 | TSB, 8'h33, 1'b1, 8'((k - rcyc) & 32'hFF), hc);
    step(2);
    check("post_rst_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
